// File: rtl/bitslam_write_sequencer.sv
// Register-write feeder for the two-voice LFSR sound core: buffers commands in a
// FWFT FIFO and replays them as address/data phases, skipping redundant address writes.
module bitslam_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_addr,
  input  logic [5:0]       cmd_data,
  output logic             bus_sel,
  output logic [5:0]       bus_data,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nx;
  logic [2:0]       mem_addr [DEPTH];
  logic [5:0]       mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [LVL_W-1:0] count;
  logic [2:0]       cur_addr, cur_addr_nx;
  logic [2:0]       head_addr, follow_addr;
  logic [5:0]       head_data, follow_data, target_data;
  logic             push, pop;
  logic             bus_sel_nx;
  logic [5:0]       bus_data_nx;

  assign cmd_ready   = (count < LVL_W'(DEPTH));
  assign push        = cmd_valid & cmd_ready;
  assign pop         = (state == DATA);
  assign rd_ptr_inc  = rd_ptr + PTR_W'(1);
  assign head_addr   = mem_addr[rd_ptr];
  assign head_data   = mem_data[rd_ptr];
  assign follow_addr = mem_addr[rd_ptr_inc];
  assign follow_data = mem_data[rd_ptr_inc];
  assign fifo_level  = count;
  assign busy        = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cmd_addr;
      mem_data[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register; bus outputs are registered alongside it so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_addr <= '0;
      bus_sel  <= 1'b0;
      bus_data <= '0;
    end else begin
      state    <= state_nx;
      cur_addr <= cur_addr_nx;
      bus_sel  <= bus_sel_nx;
      bus_data <= bus_data_nx;
    end
  end

  // Leaving DATA pops the head, so the decision is made on the entry behind it;
  // an entry pushed on that same edge is not yet visible, so we fall back to IDLE.
  always_comb begin
    state_nx    = state;
    cur_addr_nx = cur_addr;
    target_data = head_data;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (head_addr == cur_addr) begin
            state_nx = DATA;
          end else begin
            state_nx    = ADDR;
            cur_addr_nx = head_addr;
          end
        end
      end
      ADDR: state_nx = DATA;
      DATA: begin
        target_data = follow_data;
        if (count > LVL_W'(1)) begin
          if (follow_addr == cur_addr) begin
            state_nx = DATA;
          end else begin
            state_nx    = ADDR;
            cur_addr_nx = follow_addr;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus_sel_nx  = 1'b0;
    bus_data_nx = {3'b000, cur_addr_nx};
    case (state_nx)
      DATA: begin
        bus_sel_nx  = 1'b1;
        bus_data_nx = target_data;
      end
      default: begin
        bus_sel_nx  = 1'b0;
        bus_data_nx = {3'b000, cur_addr_nx};
      end
    endcase
  end

endmodule

// File: tb/tb_bitslam_write_sequencer.sv
// Directed bench for bitslam_write_sequencer with a tiny model of the sound core's
// register file latching the bus, checked with immediate assertions.
module tb_bitslam_write_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [5:0] cmd_data;
  logic       bus_sel;
  logic [5:0] bus_data;
  logic       busy;
  logic [2:0] fifo_level;

  int assertCount = 0;
  int failCount   = 0;

  logic [5:0] core_reg [8] = '{default: 6'd0};
  logic [2:0] core_addr = 3'd0;

  bitslam_write_sequencer #(.DEPTH(4), .LVL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .bus_sel    (bus_sel),
    .bus_data   (bus_data),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The core latches the address while select is low and writes data while high.
  always @(posedge clk) begin
    if (bus_sel) core_reg[core_addr] <= bus_data;
    else         core_addr <= bus_data[2:0];
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete (observed timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [5:0] d);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int         k;
    int         j;
    int         peak;
    logic       acc;
    logic       sawLow;
    logic [5:0] expData [7];
    logic       expSel  [7];
    logic       selLog  [24];
    logic [5:0] dataLog [24];

    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 6'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    #1;
    checkOutput("resetReady", {7'd0, cmd_ready}, 8'd1);
    checkOutput("resetLevel", {5'd0, fifo_level}, 8'd0);

    // Idle after reset: address 0 rewritten every cycle
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("idleSel",   {7'd0, bus_sel}, 8'd0);
      checkOutput("idleData",  {2'd0, bus_data}, 8'h00);
      checkOutput("idleBusy",  {7'd0, busy}, 8'd0);
      checkOutput("idleReady", {7'd0, cmd_ready}, 8'd1);
    end

    // Same address as held: data right after E+1
    applyStimulus(1'b1, 3'd0, 6'h2A);
    tick();
    applyStimulus(1'b0, 3'd0, 6'h00);
    checkOutput("sameE0Sel",   {7'd0, bus_sel}, 8'd0);
    checkOutput("sameE0Level", {5'd0, fifo_level}, 8'd1);
    checkOutput("sameE0Busy",  {7'd0, busy}, 8'd1);
    tick();
    checkOutput("sameE1Sel",  {7'd0, bus_sel}, 8'd1);
    checkOutput("sameE1Data", {2'd0, bus_data}, 8'h2A);
    tick();
    checkOutput("sameE2Sel",   {7'd0, bus_sel}, 8'd0);
    checkOutput("sameE2Data",  {2'd0, bus_data}, 8'h00);
    checkOutput("sameE2Level", {5'd0, fifo_level}, 8'd0);
    checkOutput("sameE2Busy",  {7'd0, busy}, 8'd0);
    checkOutput("coreReg0",    {2'd0, core_reg[0]}, 8'h2A);

    // New address: address phase then data phase
    applyStimulus(1'b1, 3'd5, 6'h3F);
    tick();
    applyStimulus(1'b0, 3'd0, 6'h00);
    checkOutput("newE0Data", {2'd0, bus_data}, 8'h00);
    tick();
    checkOutput("newE1Sel",  {7'd0, bus_sel}, 8'd0);
    checkOutput("newE1Data", {2'd0, bus_data}, 8'h05);
    tick();
    checkOutput("newE2Sel",  {7'd0, bus_sel}, 8'd1);
    checkOutput("newE2Data", {2'd0, bus_data}, 8'h3F);
    tick();
    checkOutput("newE3Sel",  {7'd0, bus_sel}, 8'd0);
    checkOutput("newE3Data", {2'd0, bus_data}, 8'h05);
    checkOutput("coreReg5",  {2'd0, core_reg[5]}, 8'h3F);

    // Four back-to-back writes to register 2 (held address is 5)
    expSel  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    expData = '{6'h05, 6'h02, 6'h11, 6'h12, 6'h13, 6'h14, 6'h02};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        applyStimulus(1'b1, 3'd2, 6'h11 + 6'(i));
        checkOutput("b2bReady", {7'd0, cmd_ready}, 8'd1);
      end else begin
        applyStimulus(1'b0, 3'd0, 6'h00);
      end
      tick();
      checkOutput("b2bSel",  {7'd0, bus_sel}, {7'd0, expSel[i]});
      checkOutput("b2bData", {2'd0, bus_data}, {2'd0, expData[i]});
    end
    checkOutput("b2bCoreReg2", {2'd0, core_reg[2]}, 8'h14);

    // Alternating registers 1/3 with a source that holds refused commands
    k = 0;
    peak = 0;
    sawLow = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (k < 6) applyStimulus(1'b1, (k % 2 == 0) ? 3'd1 : 3'd3, 6'h21 + 6'(k));
      else       applyStimulus(1'b0, 3'd0, 6'h00);
      acc = cmd_valid && cmd_ready;
      if (cmd_valid && !cmd_ready) sawLow = 1'b1;
      tick();
      if (acc) k++;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      selLog[c]  = bus_sel;
      dataLog[c] = bus_data;
    end
    checkOutput("stallAccepted", 8'(k), 8'd6);
    checkOutput("stallPeak",     8'(peak), 8'd4);
    checkOutput("stallReadyLow", {7'd0, sawLow}, 8'd1);
    j = 0;
    for (int c = 1; c < 24; c++) begin
      if (selLog[c]) begin
        checkOutput("stallData",    {2'd0, dataLog[c]}, 8'h21 + 8'(j));
        checkOutput("stallAddrSel", {7'd0, selLog[c-1]}, 8'd0);
        checkOutput("stallAddr",    {2'd0, dataLog[c-1]}, (j % 2 == 0) ? 8'h01 : 8'h03);
        j++;
      end
    end
    checkOutput("stallDataCount", 8'(j), 8'd6);
    checkOutput("stallCoreReg1",  {2'd0, core_reg[1]}, 8'h25);
    checkOutput("stallCoreReg3",  {2'd0, core_reg[3]}, 8'h26);

    // Reset asserted during a DATA cycle with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd4, 6'h01 + 6'(i));
      tick();
    end
    applyStimulus(1'b0, 3'd0, 6'h00);
    checkOutput("preRstSel",   {7'd0, bus_sel}, 8'd1);
    checkOutput("preRstData",  {2'd0, bus_data}, 8'h01);
    checkOutput("preRstLevel", {5'd0, fifo_level}, 8'd3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstSel",   {7'd0, bus_sel}, 8'd0);
    checkOutput("rstData",  {2'd0, bus_data}, 8'h00);
    checkOutput("rstLevel", {5'd0, fifo_level}, 8'd0);
    checkOutput("rstBusy",  {7'd0, busy}, 8'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("postRstSel",   {7'd0, bus_sel}, 8'd0);
      checkOutput("postRstData",  {2'd0, bus_data}, 8'h00);
      checkOutput("postRstLevel", {5'd0, fifo_level}, 8'd0);
      checkOutput("postRstReady", {7'd0, cmd_ready}, 8'd1);
    end
    checkOutput("postRstCoreReg4", {2'd0, core_reg[4]}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
